// File: rtl/modport_counter_pkg.sv
// Shared constants and types for the loadable up/down counter.
package modport_counter_pkg;

    localparam int DATA_W = 32;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    typedef logic [DATA_W-1:0] cnt_t;

endpackage : modport_counter_pkg

// File: rtl/modport_counter_next.sv
// Combinational next-state for the counter: load has priority over stepping.
module modport_counter_next
    import modport_counter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic              mode,
    output logic [DATA_W-1:0] nxt
);

    always_comb begin
        // NOTE: a default first on every path keeps always_comb free of inferred latches.
        nxt = cur;
        if (load) begin
            nxt = data;
        end else if (mode == MODE_UP) begin
            nxt = cur + DATA_W'(1);
        end else begin
            nxt = cur - DATA_W'(1);
        end
    end

endmodule : modport_counter_next

// File: rtl/modport_counter.sv
// Loadable up/down counter: async active-low reset register around the next-state logic.
module modport_counter
    import modport_counter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              mode,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;

    modport_counter_next #(
        .DATA_W (DATA_W)
    ) u_next (
        .cur  (cnt_q),
        .data (data),
        .load (load),
        .mode (mode),
        .nxt  (cnt_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_out = cnt_q;

endmodule : modport_counter

// File: tb/tb_modport_counter.sv
// Self-checking bench for modport_counter: directed scenarios plus randomized run vs. an arithmetic model.
module tb_modport_counter;
    import modport_counter_pkg::*;

    logic        clk;
    logic        rst;
    logic        load;
    logic        mode;
    cnt_t        data;
    cnt_t        data_out;

    int total = 0;
    int bad   = 0;

    // Reference value held as a wide integer; wrap is applied with modulo 2**32.
    longint unsigned model;

    modport_counter #(
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .mode     (mode),
        .data     (data),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam longint unsigned MODULUS = 64'h1_0000_0000;

    function automatic longint unsigned ref_next(longint unsigned cur, bit l, bit m, cnt_t d);
        if (l) return longint'(d);
        if (m) return (cur + 1) % MODULUS;
        return (cur + MODULUS - 1) % MODULUS;
    endfunction

    // Apply inputs, advance one rising edge, settle; model tracks the spec rules.
    task automatic tick(input bit l, input bit m, input cnt_t d);
        load = l;
        mode = m;
        data = d;
        @(posedge clk);
        #1;
        model = ref_next(model, l, m, d);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 32'h1234_5678);
        total++;
        if (data_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL reset_preload: got %h expected %h", data_out, 32'h1234_5678);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_async: got %h expected %h", data_out, 32'h0);
        end
        load = 1'b1;
        data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold: got %h expected %h", data_out, 32'h0);
        end
        #2;
        rst = 1'b1;
        model = 0;
    endtask

    task automatic test_load_up();
        cnt_t exp_seq [4];
        exp_seq[0] = 32'h0000_00FF;
        exp_seq[1] = 32'h0000_0100;
        exp_seq[2] = 32'h0000_0101;
        exp_seq[3] = 32'h0000_0102;
        tick(1'b1, 1'b0, 32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(1'b0, 1'b1, $urandom);
            total++;
            if (data_out !== exp_seq[i] || data_out !== cnt_t'(model)) begin
                bad++;
                $display("FAIL load_up[%0d]: got %h expected %h", i, data_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_down_wrap();
        tick(1'b1, 1'b1, 32'h0000_0001);
        tick(1'b0, 1'b0, 32'h0);
        total++;
        if (data_out !== 32'h0000_0000) begin
            bad++;
            $display("FAIL down_wrap_zero: got %h expected %h", data_out, 32'h0);
        end
        tick(1'b0, 1'b0, 32'h0);
        total++;
        if (data_out !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL down_wrap_ones: got %h expected %h", data_out, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_up_wrap();
        tick(1'b1, 1'b0, 32'hFFFF_FFFE);
        tick(1'b0, 1'b1, 32'h0);
        total++;
        if (data_out !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL up_wrap_ones: got %h expected %h", data_out, 32'hFFFF_FFFF);
        end
        tick(1'b0, 1'b1, 32'h0);
        total++;
        if (data_out !== 32'h0000_0000) begin
            bad++;
            $display("FAIL up_wrap_zero: got %h expected %h", data_out, 32'h0);
        end
    endtask

    task automatic test_load_priority();
        cnt_t exp;
        tick(1'b1, 1'b1, 32'hA5A5_A5A5);
        total++;
        if (data_out !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL load_priority: got %h expected %h", data_out, 32'hA5A5_A5A5);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, (i % 2 == 0), $urandom);
            exp = (i % 2 == 0) ? 32'hA5A5_A5A6 : 32'hA5A5_A5A5;
            total++;
            if (data_out !== exp) begin
                bad++;
                $display("FAIL mode_toggle[%0d]: got %h expected %h", i, data_out, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b1, 32'h0000_1000);
        tick(1'b0, 1'b1, 32'h0);
        tick(1'b0, 1'b1, 32'h0);
        total++;
        if (data_out !== 32'h0000_1002) begin
            bad++;
            $display("FAIL pre_reset_count: got %h expected %h", data_out, 32'h0000_1002);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (data_out !== 32'h0) begin
            bad++;
            $display("FAIL midrun_reset: got %h expected %h", data_out, 32'h0);
        end
        rst   = 1'b1;
        model = 0;
        tick(1'b0, 1'b1, 32'h0);
        total++;
        if (data_out !== 32'h0000_0001) begin
            bad++;
            $display("FAIL post_reset_step: got %h expected %h", data_out, 32'h0000_0001);
        end
    endtask

    task automatic test_random();
        bit   l;
        bit   m;
        cnt_t d;
        int   errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            l = ($urandom_range(0, 3) == 0);
            m = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       d = 32'h0;
                1:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            tick(l, m, d);
            total++;
            if (data_out !== cnt_t'(model)) begin
                bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: got %h expected %h", i, data_out, cnt_t'(model));
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        mode  = 1'b0;
        data  = '0;
        model = 0;
        #12;
        total++;
        if (data_out !== 32'h0) begin
            bad++;
            $display("FAIL initial_reset: got %h expected %h", data_out, 32'h0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        model = 0;
        test_reset();
        test_load_up();
        test_down_wrap();
        test_up_wrap();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_modport_counter
